hack_gate_checker: RTL and testbench

Synthesizable response checker for the Hack gate library: the receiving end of a gate stimulus sequence. It observes applied inputs `a`, `b` and the gate-under-test output `out`. After a settle delay it compares `out` against the expected two-input function, and it tracks mismatches, vector count and truth-table coverage. It sits beside any base gate (`hOr`, `hAnd`, …) on the board-level self-test harness and turns a stimulus run into a single pass/fail verdict.

---
 rtl/hack_gate_pkg.sv | 27 ++
 rtl/hack_gate_ref.sv | 26 ++
 rtl/hack_gate_checker.sv | 172 +++++++++++++++++
 tb/tb_hack_gate_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_gate_pkg.sv
// Shared encodings for the Hack gate response checker.
// Gate function codes, checker FSM states and helpers.
package hack_gate_pkg;

  localparam int unsigned FUNC_W = 3;

  localparam logic [FUNC_W-1:0] F_AND  = 3'd0;
  localparam logic [FUNC_W-1:0] F_OR   = 3'd1;
  localparam logic [FUNC_W-1:0] F_NAND = 3'd2;
  localparam logic [FUNC_W-1:0] F_NOR  = 3'd3;
  localparam logic [FUNC_W-1:0] F_XOR  = 3'd4;
  localparam logic [FUNC_W-1:0] F_XNOR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic func_legal(
    input logic [FUNC_W-1:0] f
  );
    return (f <= F_XNOR);
  endfunction

endpackage

// File: rtl/hack_gate_ref.sv
// Combinational reference model of a two-input Hack gate.
// Illegal function codes produce 0.
module hack_gate_ref
  import hack_gate_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  input  logic              a,
  input  logic              b,
  output logic              exp
);

  // Decode the expected gate output
  always_comb begin
    exp = 1'b0;
    unique case (func)
      F_AND:   exp = a & b;
      F_OR:    exp = a | b;
      F_NAND:  exp = ~(a & b);
      F_NOR:   exp = ~(a | b);
      F_XOR:   exp = a ^ b;
      F_XNOR:  exp = ~(a ^ b);
      default: exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/hack_gate_checker.sv
// Response checker for Hack base gates: settle, compare, count, cover.
// Define HACK_GATE_CHECK_CAPTURE_EN to add first-failure capture ports.
module hack_gate_checker
  import hack_gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FUNC_W-1:0] func,
  input  logic              in_valid,
  input  logic              a,
  input  logic              b,
  input  logic              out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [3:0]        cov
`ifdef HACK_GATE_CHECK_CAPTURE_EN
  ,
  output logic [1:0]        fail_ab,
  output logic              fail_out,
  output logic [CNT_W-1:0]  fail_idx
`endif
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [FUNC_W-1:0]  func_q, func_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [3:0]         cov_q, cov_d;
  logic               exp_w;
  logic               mism_w;
  logic               cmp_w;

  hack_gate_ref u_ref (
    .func (func_q),
    .a    (a_q),
    .b    (b_q),
    .exp  (exp_w)
  );

  assign mism_w = out ^ exp_w;

  // Next-state logic: start wins, then new vectors, then compare
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vec_d   = vec_q;
    cov_d   = cov_q;
    cmp_w   = 1'b0;
    if (start) begin
      func_d  = func;
      a_d     = 1'b0;
      b_d     = 1'b0;
      cnt_d   = '0;
      err_d   = '0;
      vec_d   = '0;
      cov_d   = '0;
      state_d = func_legal(func) ? S_ARMED : S_DONE;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            cnt_d   = SETTLE;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            a_d   = a;
            b_d   = b;
            cnt_d = SETTLE;
          end else if (cnt_q <= 8'd1) begin
            cmp_w = 1'b1;
            cnt_d = '0;
            if (vec_q != CNT_MAX)
              vec_d = vec_q + CNT_ONE;
            if (mism_w && err_q != CNT_MAX)
              err_d = err_q + CNT_ONE;
            cov_d = cov_q | (4'b0001 << {a_q, b_q});
            state_d = (&cov_d) ? S_DONE : S_ARMED;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Checker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      func_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      vec_q   <= '0;
      cov_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      cov_q   <= cov_d;
    end
  end

  assign busy    = (state_q == S_ARMED) || (state_q == S_WAIT);
  assign done    = (state_q == S_DONE);
  assign pass    = done && (err_q == '0) && func_legal(func_q);
  assign err_cnt = err_q;
  assign vec_cnt = vec_q;
  assign cov     = cov_q;

`ifdef HACK_GATE_CHECK_CAPTURE_EN
  logic              seen_q;
  logic [1:0]        fail_ab_q;
  logic              fail_out_q;
  logic [CNT_W-1:0]  fail_idx_q;

  // Keep only the first mismatch of a run, indexed by its vec_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q     <= 1'b0;
      fail_ab_q  <= '0;
      fail_out_q <= 1'b0;
      fail_idx_q <= '0;
    end else if (start) begin
      seen_q     <= 1'b0;
      fail_ab_q  <= '0;
      fail_out_q <= 1'b0;
      fail_idx_q <= '0;
    end else if (cmp_w && mism_w && !seen_q) begin
      seen_q     <= 1'b1;
      fail_ab_q  <= {a_q, b_q};
      fail_out_q <= out;
      fail_idx_q <= vec_q;
    end
  end

  assign fail_ab  = fail_ab_q;
  assign fail_out = fail_out_q;
  assign fail_idx = fail_idx_q;
`endif

endmodule

// File: tb/tb_hack_gate_checker.sv
// Directed bench for hack_gate_checker (default and CNT_W=2 copies).
// Both copies share stimulus; expectations are hand-computed.
module tb_hack_gate_checker;
  import hack_gate_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] func;
  logic       in_valid;
  logic       a;
  logic       b;
  logic       out;

  logic       busy, done, pass;
  logic [7:0] err_cnt, vec_cnt;
  logic [3:0] cov;

  logic       s_busy, s_done, s_pass;
  logic [1:0] s_err, s_vec;
  logic [3:0] s_cov;

`ifdef HACK_GATE_CHECK_CAPTURE_EN
  logic [1:0] fail_ab, s_fail_ab;
  logic       fail_out, s_fail_out;
  logic [7:0] fail_idx;
  logic [1:0] s_fail_idx;
`endif

  int checks;
  int failures;

  hack_gate_checker u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .func     (func),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .vec_cnt  (vec_cnt),
    .cov      (cov)
`ifdef HACK_GATE_CHECK_CAPTURE_EN
    ,
    .fail_ab  (fail_ab),
    .fail_out (fail_out),
    .fail_idx (fail_idx)
`endif
  );

  hack_gate_checker #(
    .SETTLE_CYCLES (4),
    .CNT_W         (2)
  ) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .func     (func),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out      (out),
    .busy     (s_busy),
    .done     (s_done),
    .pass     (s_pass),
    .err_cnt  (s_err),
    .vec_cnt  (s_vec),
    .cov      (s_cov)
`ifdef HACK_GATE_CHECK_CAPTURE_EN
    ,
    .fail_ab  (s_fail_ab),
    .fail_out (s_fail_out),
    .fail_idx (s_fail_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] f);
    start = 1'b1;
    func  = f;
    tick();
    start = 1'b0;
  endtask

  // One vector: in_valid for one edge, response held through compare
  task automatic apply(input logic va, input logic vb,
                       input logic vo);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    out      = vo;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    func     = 3'd0;
    in_valid = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    out      = 1'b0;
    repeat (2) tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_vec", 32'(vec_cnt), 32'd0);
    check("rst_cov", 32'(cov), 32'd0);
    rst_n = 1'b1;
    tick();

    // OR gate, all correct responses
    pulse_start(3'd1);
    check("or_busy", 32'(busy), 32'd1);
    check("or_done0", 32'(done), 32'd0);
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, 1'b1);
    check("or_vec3", 32'(vec_cnt), 32'd3);
    check("or_cov3", 32'(cov), 32'h7);
    check("or_busy3", 32'(busy), 32'd1);
    apply(1'b1, 1'b1, 1'b1);
    check("or_done", 32'(done), 32'd1);
    check("or_pass", 32'(pass), 32'd1);
    check("or_vec", 32'(vec_cnt), 32'd4);
    check("or_err", 32'(err_cnt), 32'd0);
    check("or_cov", 32'(cov), 32'hf);
    check("or_busy_end", 32'(busy), 32'd0);

    // DONE ignores further vectors
    apply(1'b0, 1'b0, 1'b1);
    check("hold_vec", 32'(vec_cnt), 32'd4);
    check("hold_err", 32'(err_cnt), 32'd0);
    check("hold_pass", 32'(pass), 32'd1);

    // AND expected, OR-like responses: 01 and 10 mismatch
    pulse_start(3'd0);
    check("and_clr_vec", 32'(vec_cnt), 32'd0);
    check("and_clr_cov", 32'(cov), 32'd0);
    check("and_clr_done", 32'(done), 32'd0);
    apply(1'b0, 1'b1, 1'b1);
    check("and_err1", 32'(err_cnt), 32'd1);
    apply(1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    check("and_done", 32'(done), 32'd1);
    check("and_pass", 32'(pass), 32'd0);
    check("and_err", 32'(err_cnt), 32'd2);
    check("and_vec", 32'(vec_cnt), 32'd4);
`ifdef HACK_GATE_CHECK_CAPTURE_EN
    check("cap_ab", 32'(fail_ab), 32'h1);
    check("cap_out", 32'(fail_out), 32'd1);
    check("cap_idx", 32'(fail_idx), 32'd0);
`endif

    // Second in_valid 2 cycles into WAIT discards the first
    pulse_start(3'd1);
    in_valid = 1'b1;
    a        = 1'b0;
    b        = 1'b0;
    out      = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    a        = 1'b1;
    b        = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("disc_vec_t4", 32'(vec_cnt), 32'd0);
    tick();
    check("disc_vec_t5", 32'(vec_cnt), 32'd0);
    tick();
    check("disc_vec", 32'(vec_cnt), 32'd1);
    check("disc_cov", 32'(cov), 32'h8);
    check("disc_err", 32'(err_cnt), 32'd0);
    check("disc_busy", 32'(busy), 32'd1);

    // start coincident with compare wins and restarts
    in_valid = 1'b1;
    a        = 1'b0;
    b        = 1'b0;
    out      = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    pulse_start(3'd2);
    check("rst_cmp_vec", 32'(vec_cnt), 32'd0);
    check("rst_cmp_cov", 32'(cov), 32'd0);
    check("rst_cmp_busy", 32'(busy), 32'd1);
    apply(1'b1, 1'b1, 1'b0);
    check("nand_vec", 32'(vec_cnt), 32'd1);
    check("nand_err", 32'(err_cnt), 32'd0);
    check("nand_cov", 32'(cov), 32'h8);

    // Illegal function goes straight to DONE
    pulse_start(3'd7);
    check("ill_done", 32'(done), 32'd1);
    check("ill_pass", 32'(pass), 32'd0);
    check("ill_vec", 32'(vec_cnt), 32'd0);
    check("ill_busy", 32'(busy), 32'd0);

    // Six mismatches on 00: 2-bit counters saturate at 3
    pulse_start(3'd0);
    repeat (6) apply(1'b0, 1'b0, 1'b1);
    check("sat_err", 32'(s_err), 32'd3);
    check("sat_vec", 32'(s_vec), 32'd3);
    check("sat_busy", 32'(s_busy), 32'd1);
    check("wide_err", 32'(err_cnt), 32'd6);
    check("wide_vec", 32'(vec_cnt), 32'd6);
    check("sat_cov", 32'(s_cov), 32'h1);

    // Reset mid-WAIT clears outputs immediately
    in_valid = 1'b1;
    a        = 1'b0;
    b        = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err", 32'(err_cnt), 32'd0);
    check("arst_vec", 32'(vec_cnt), 32'd0);
    check("arst_cov", 32'(cov), 32'd0);
    check("arst_sat_err", 32'(s_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // IDLE ignores in_valid until start
    apply(1'b1, 1'b1, 1'b0);
    tick();
    check("idle_vec", 32'(vec_cnt), 32'd0);
    check("idle_cov", 32'(cov), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
